fifo_write_arbiter: RTL and testbench



---
 rtl/fifo_write_arbiter.sv | 171 +++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_arbiter
// Purpose  : Round-robin arbiter sharing the single write port of an
//            asynchronous FIFO between several write-domain requesters. One
//            requester is granted at a time for a burst of at most BURST_LEN
//            words. Every grant is followed by one idle cycle.
// Ports    : clk, reset          - write clock, synchronous active-high reset
//            req_valid/req_data  - per-requester word offer (packed data)
//            req_ready           - per-requester accept (valid & ready = xfer)
//            fifo_full           - FIFO full flag, consumed in the same cycle
//            fifo_write_enable   - FIFO write strobe
//            fifo_write_data     - FIFO write word (grantee's data)
//            grant_id            - current or most recent grantee
//            busy                - high while a grant is active
//            stall_count         - only with FIFO_WRITE_ARBITER_STALL_COUNT_EN:
//                                  saturating count of cycles in which the
//                                  grantee was valid but the FIFO was full
// Config   : `define FIFO_WRITE_ARBITER_STALL_COUNT_EN adds stall_count.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int REQUESTERS = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [REQUESTERS-1:0]            req_valid,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] req_data,
    output logic [REQUESTERS-1:0]            req_ready,
    input  logic                             fifo_full,
    output logic                             fifo_write_enable,
    output logic [DATA_WIDTH-1:0]            fifo_write_data,
    output logic [$clog2(REQUESTERS)-1:0]    grant_id,
`ifdef FIFO_WRITE_ARBITER_STALL_COUNT_EN
    output logic [15:0]                      stall_count,
`endif
    output logic                             busy
);

    localparam int c_GID_W  = $clog2(REQUESTERS);
    localparam int c_BEAT_W = $clog2(BURST_LEN + 1);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_LEN - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_GID_W-1:0]   r_grant_id;
    logic [c_GID_W-1:0]   w_grant_id_next;
    logic [c_GID_W-1:0]   r_last_grant;
    logic [c_GID_W-1:0]   w_last_grant_next;
    logic [c_BEAT_W-1:0]  r_beat_count;
    logic [c_BEAT_W-1:0]  w_beat_count_next;

    logic                 w_sel_found;
    logic [c_GID_W-1:0]   w_sel;
    logic                 w_grant_valid;
    logic                 w_xfer;

    // Round-robin pick: first valid requester strictly after the last
    // grantee, wrapping. The wrap is a conditional subtract so that
    // non-power-of-two requester counts need no modulo hardware.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel       = '0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            int idx;
            idx = int'(r_last_grant) + k;
            if (idx >= REQUESTERS) begin
                idx = idx - REQUESTERS;
            end
            if (!w_sel_found && req_valid[idx]) begin
                w_sel_found = 1'b1;
                w_sel       = c_GID_W'(idx);
            end
        end
    end

    // Control depends only on valid, full and registered state; data is
    // steered separately so no data bit reaches a control output.
    assign w_grant_valid = req_valid[r_grant_id];
    assign w_xfer        = (r_state == S_GRANT) && w_grant_valid && !fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= c_GID_W'(REQUESTERS - 1);
            r_beat_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_grant_id   <= w_grant_id_next;
            r_last_grant <= w_last_grant_next;
            r_beat_count <= w_beat_count_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_grant_id_next   = r_grant_id;
        w_last_grant_next = r_last_grant;
        w_beat_count_next = r_beat_count;
        case (r_state)
            S_IDLE: begin
                if (w_sel_found) begin
                    w_state_next      = S_GRANT;
                    w_grant_id_next   = w_sel;
                    w_beat_count_next = '0;
                end
            end
            S_GRANT: begin
                if (!w_grant_valid) begin
                    // Grantee withdrew: the rest of its burst is forfeited.
                    w_state_next      = S_IDLE;
                    w_last_grant_next = r_grant_id;
                end else if (w_xfer) begin
                    if (r_beat_count == c_LAST_BEAT) begin
                        w_state_next      = S_IDLE;
                        w_last_grant_next = r_grant_id;
                    end else begin
                        w_beat_count_next = r_beat_count + 1'b1;
                    end
                end
                // Valid but full: everything holds, grant is kept.
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    assign fifo_write_enable = w_xfer;
    assign busy              = (r_state == S_GRANT);
    assign grant_id          = r_grant_id;
    // Grantee data is presented for the whole grant, enabled or not; it is
    // zeroed in IDLE so the port is quiet between grants and after reset.
    assign fifo_write_data   = (r_state == S_GRANT)
                             ? req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH]
                             : '0;

`ifdef FIFO_WRITE_ARBITER_STALL_COUNT_EN
    logic [15:0] r_stall_count;
    logic        w_stall;

    assign w_stall = (r_state == S_GRANT) && w_grant_valid && fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_write_arbiter
// Purpose  : Self-checking bench for fifo_write_arbiter (DATA_WIDTH 8,
//            REQUESTERS 4, BURST_LEN 4). Requesters are word queues; the
//            expected FIFO write stream is derived from the round-robin /
//            burst rules and compared by a monitor on every write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int BL = 4;

    logic            clk;
    logic            reset;
    logic [R-1:0]    req_valid;
    logic [R*DW-1:0] req_data;
    logic [R-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_write_enable;
    logic [DW-1:0]   fifo_write_data;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef FIFO_WRITE_ARBITER_STALL_COUNT_EN
    logic [15:0]     stall_count;
`endif

    fifo_write_arbiter #(.DATA_WIDTH(DW), .REQUESTERS(R), .BURST_LEN(BL)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .fifo_full         (fifo_full),
        .fifo_write_enable (fifo_write_enable),
        .fifo_write_data   (fifo_write_data),
        .grant_id          (grant_id),
`ifdef FIFO_WRITE_ARBITER_STALL_COUNT_EN
        .stall_count       (stall_count),
`endif
        .busy              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic [7:0] src [R][$];
    exp_t       exp_q [$];
    int         xfer_cnt [R];
    int         checks = 0;
    int         errors = 0;
    int         m_last = R - 1;
    int         burst_writes = 0;
    int         last_burst = 0;
    bit         gap_pending = 0;
    bit         rst_next = 1;
    bit         full_next = 0;
    bit         full_rand = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Advance one clock and drive requester inputs from the source queues.
    task automatic tick();
        @(posedge clk);
        #1;
        reset     = rst_next;
        fifo_full = full_rand ? ($urandom_range(0, 3) == 0) : full_next;
        for (int i = 0; i < R; i++) begin
            if (src[i].size() > 0) begin
                req_valid[i]        = 1'b1;
                req_data[i*DW +: DW] = src[i][0];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic load(input int i, input int n, input logic [7:0] base, input bit rnd);
        for (int j = 0; j < n; j++) begin
            src[i].push_back(rnd ? 8'($urandom) : 8'(base + 8'(j)));
        end
    endtask

    // Reference: requesters hold valid until their queue drains, so the
    // write stream is round-robin from the last grantee, min(BL, remaining)
    // words per grant, independent of full timing.
    task automatic push_model();
        int rem [R];
        int pos [R];
        for (int i = 0; i < R; i++) begin
            rem[i] = src[i].size();
            pos[i] = 0;
        end
        for (int guard = 0; guard < 1000; guard++) begin
            int  sel;
            int  n;
            bit  found;
            found = 0;
            sel   = 0;
            for (int k = 1; k <= R; k++) begin
                int c;
                c = (m_last + k) % R;
                if (!found && rem[c] > 0) begin
                    found = 1;
                    sel   = c;
                end
            end
            if (!found) break;
            n = (rem[sel] < BL) ? rem[sel] : BL;
            for (int j = 0; j < n; j++) begin
                exp_q.push_back('{id: sel, data: src[sel][pos[sel] + j]});
            end
            pos[sel] += n;
            rem[sel] -= n;
            m_last    = sel;
        end
    endtask

    function automatic bit pending();
        bit p;
        p = (exp_q.size() > 0);
        for (int i = 0; i < R; i++) if (src[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic run_phase(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (pending() && n < budget);
        chk(n < budget, "phase_timeout", n, budget);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst_next = 1;
        tick();
        tick();
        rst_next = 0;
        m_last   = R - 1;
    endtask

    task automatic chk_quiet(input string name);
        #1;
        chk({busy, fifo_write_enable, req_ready, grant_id, fifo_write_data} == '0,
            name, {busy, fifo_write_enable, req_ready, grant_id, fifo_write_data}, 0);
    endtask

    // Monitor: consumes handshakes, checks every write against the
    // scoreboard and checks cycle-level arbitration rules.
    always @(negedge clk) begin
        for (int i = 0; i < R; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                if (src[i].size() > 0) void'(src[i].pop_front());
                xfer_cnt[i]++;
            end
        end
        if (fifo_full)
            chk(!fifo_write_enable && req_ready == '0, "write_while_full",
                {fifo_write_enable, req_ready}, 0);
        chk(fifo_write_enable == (req_ready != '0), "enable_vs_ready",
            fifo_write_enable, req_ready != '0);
        if (req_ready != '0)
            chk(busy && req_ready == (4'b0001 << grant_id), "ready_onehot",
                req_ready, 4'b0001 << grant_id);
        if (fifo_write_enable) begin
            if (exp_q.size() == 0) begin
                chk(0, "unexpected_write", {grant_id, fifo_write_data}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk(int'(grant_id) == e.id && fifo_write_data == e.data, "write_word",
                    {grant_id, fifo_write_data}, {2'(e.id), e.data});
            end
            burst_writes++;
            chk(burst_writes <= BL, "burst_len", burst_writes, BL);
        end
        if (gap_pending) chk(busy, "single_idle_gap", busy, 1);
        gap_pending = !busy && (req_valid != '0) && !reset;
        if (!busy && burst_writes > 0) begin
            last_burst   = burst_writes;
            burst_writes = 0;
        end
    end

    initial begin
        int pb [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
        int pw [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        int b;
        reset     = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < R; i++) xfer_cnt[i] = 0;

        // Reset state
        tick();
        tick();
        chk_quiet("reset_outputs");
`ifdef FIFO_WRITE_ARBITER_STALL_COUNT_EN
        chk(stall_count == 16'h0, "reset_stall_count", stall_count, 0);
`endif

        // Single requester, 6 words: 4-word burst, idle cycle, 2-word burst
        load(0, 6, 8'hA0, 0);
        push_model();
        rst_next = 0;
        m_last   = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            #1;
            chk(busy == pb[k][0], "t1_busy", busy, pb[k]);
            chk(fifo_write_enable == pw[k][0], "t1_write_enable", fifo_write_enable, pw[k]);
        end
        chk(exp_q.size() == 0, "t1_all_written", exp_q.size(), 0);

        // All four continuously valid from reset: 0,1,2,3,0,1,2,3
        do_reset();
        for (int i = 0; i < R; i++) load(i, 8, 8'(8'h10 * (i + 1)), 0);
        push_model();
        run_phase(200);
        chk(last_burst == BL, "t2_last_burst", last_burst, BL);

        // Requester 1 offers only 2 words while 3 waits
        b = xfer_cnt[1];
        load(1, 2, 8'hB0, 0);
        load(3, 4, 8'hC0, 0);
        push_model();
        run_phase(100);
        chk(xfer_cnt[1] - b == 2, "t3_req1_transfers", xfer_cnt[1] - b, 2);

        // Reset asserted during word 2 of a burst from requester 2
        load(2, 4, 8'hD0, 0);
        exp_q.push_back('{id: 2, data: 8'hD0});
        exp_q.push_back('{id: 2, data: 8'hD1});
        b = xfer_cnt[2];
        for (int n = 0; n < 20 && xfer_cnt[2] - b < 1; n++) tick();
        chk(xfer_cnt[2] - b == 1, "t4_first_word", xfer_cnt[2] - b, 1);
        rst_next = 1;
        reset    = 1'b1;
        tick();
        chk_quiet("t4_after_reset");
        chk(exp_q.size() == 0, "t4_word2_written", exp_q.size(), 0);
        src[2].delete();
        load(2, 3, 8'hE0, 0);
        load(0, 3, 8'hF0, 0);
        m_last   = R - 1;
        push_model();
        rst_next = 0;
        run_phase(100);

        // Full for 3 cycles after the first word of a grant to requester 2
        load(2, 4, 8'h50, 0);
        push_model();
        b = xfer_cnt[2];
        for (int n = 0; n < 20 && xfer_cnt[2] - b < 1; n++) tick();
        full_next = 1;
        fifo_full = 1'b1;
        tick();
        tick();
        full_next = 0;
        run_phase(100);
        chk(last_burst == BL, "t5_burst_after_full", last_burst, BL);
`ifdef FIFO_WRITE_ARBITER_STALL_COUNT_EN
        chk(stall_count == 16'd3, "t5_stall_count", stall_count, 3);
`endif

        // Randomized phases with random full
        full_rand = 1;
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < R; i++) load(i, $urandom_range(0, 9), 8'h00, 1);
            push_model();
            run_phase(2000);
        end
        full_rand = 0;
        full_next = 0;
        repeat (3) tick();

`ifdef FIFO_WRITE_ARBITER_STALL_COUNT_EN
        // Saturation of the stall counter, then reset clears it
        load(0, 1, 8'h77, 0);
        full_next = 1;
        repeat (70000) tick();
        chk(stall_count == 16'hFFFF, "t6_stall_saturate", stall_count, 16'hFFFF);
        rst_next = 1;
        tick();
        tick();
        #1;
        chk(stall_count == 16'h0, "t6_stall_reset", stall_count, 0);
        src[0].delete();
        full_next = 0;
        do_reset();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
